oc8051_cxrom_fetch: RTL and testbench

OC8051_CXROM_FETCH -- requirements
Module: oc8051_cxrom_fetch

---
 rtl/oc8051_cxrom_fetch.sv | 118 +++++++++++
 tb/tb_oc8051_cxrom_fetch.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/oc8051_cxrom_fetch.sv
// Instruction prefetch queue for the oc8051 core fed from a 32-bit combinational code ROM.
// Optional macro OC8051_CXFETCH_BYPASS_EN: redirects fetch the target word in the redirect cycle itself.
//   state   | meaning
//   S_ALIGN | queue empty after redirect/reset; next fill drops bytes below instr_pc_o
//   S_RUN   | queue holds contiguous bytes starting at instr_pc_o
module oc8051_cxrom_fetch (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  output logic [15:0] cxrom_addr,
  input  logic [31:0] cxrom_data_in,
  input  logic        pc_load_i,
  input  logic [15:0] pc_i,
  input  logic        instr_ack_i,
  input  logic [1:0]  instr_len_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [15:0] instr_pc_o
);

  typedef enum logic {S_ALIGN, S_RUN} state_t;

  state_t      state_q, state_d;
  logic [7:0]  q_q [8];
  logic [7:0]  q_d [8];
  logic [3:0]  count_q, count_d;
  logic [15:0] fa_q, fa_d;
  logic [15:0] pc_q, pc_d;

  logic [7:0]  rom_byte [4];
  logic        honour, fill;
  logic [3:0]  consume, base, nb;
  logic [1:0]  skip_eff;
`ifdef OC8051_CXFETCH_BYPASS_EN
  logic [1:0]  pskip;
`endif

  always_comb begin
    for (int k = 0; k < 4; k++) rom_byte[k] = cxrom_data_in[8*k +: 8];
  end

  assign instr_valid_o = (count_q >= 4'd4);
  assign instr_o       = {q_q[3], q_q[2], q_q[1], q_q[0]};
  assign instr_pc_o    = pc_q;

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    fa_d       = fa_q;
    pc_d       = pc_q;
    q_d        = q_q;
    cxrom_addr = fa_q;
    honour     = 1'b0;
    fill       = 1'b0;
    consume    = 4'd0;
    base       = count_q;
    nb         = 4'd0;
    skip_eff   = 2'd0;
`ifdef OC8051_CXFETCH_BYPASS_EN
    pskip      = pc_i[1:0];
`endif

    if (pc_load_i) begin
      pc_d    = pc_i;
      fa_d    = {pc_i[15:2], 2'b00};
      count_d = 4'd0;
      state_d = S_ALIGN;
`ifdef OC8051_CXFETCH_BYPASS_EN
      // Target word is read in the redirect cycle, so the queue starts partly filled.
      cxrom_addr = {pc_i[15:2], 2'b00};
      for (int j = 0; j < 4; j++) begin
        if (j < 4 - int'(pskip)) q_d[j] = rom_byte[2'(j + int'(pskip))];
      end
      count_d = 4'd4 - {2'b00, pskip};
      fa_d    = {pc_i[15:2], 2'b00} + 16'd4;
      state_d = S_RUN;
`endif
    end else begin
      honour   = instr_valid_o && instr_ack_i && (instr_len_i != 2'd0);
      consume  = honour ? {2'b00, instr_len_i} : 4'd0;
      fill     = (count_q <= 4'd4);
      skip_eff = (state_q == S_ALIGN) ? pc_q[1:0] : 2'd0;
      base     = count_q - consume;
      nb       = fill ? (4'd4 - {2'b00, skip_eff}) : 4'd0;

      // Shift out consumed bytes, then append the ROM word behind what remains.
      for (int i = 0; i < 8; i++) begin
        if (i + int'(consume) < 8) q_d[i] = q_q[3'(i + int'(consume))];
        else                       q_d[i] = 8'h00;
        if (fill && (i >= int'(base)) && (i < int'(base) + int'(nb)))
          q_d[i] = rom_byte[2'(i - int'(base) + int'(skip_eff))];
      end

      count_d = base + nb;
      pc_d    = pc_q + {12'd0, consume};
      if (fill) begin
        fa_d    = fa_q + 16'd4;
        state_d = S_RUN;
      end
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q <= S_ALIGN;
      count_q <= 4'd0;
      fa_q    <= 16'h0000;
      pc_q    <= 16'h0000;
      for (int i = 0; i < 8; i++) q_q[i] <= 8'h00;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      fa_q    <= fa_d;
      pc_q    <= pc_d;
      q_q     <= q_d;
    end
  end

endmodule

// File: tb/tb_oc8051_cxrom_fetch.sv
// Bench for oc8051_cxrom_fetch: directed vector table plus randomized traffic against a byte-queue model.
// Honours OC8051_CXFETCH_BYPASS_EN the same way as the design.
module tb_oc8051_cxrom_fetch;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_ni = 1'b0;
  logic [15:0] cxrom_addr;
  logic [31:0] cxrom_data_in;
  logic        pc_load_i = 1'b0;
  logic [15:0] pc_i = 16'h0000;
  logic        instr_ack_i = 1'b0;
  logic [1:0]  instr_len_i = 2'd0;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [15:0] instr_pc_o;

  int vectors = 0;
  int miscompares = 0;

  oc8051_cxrom_fetch dut (
    .wb_clk_i      (wb_clk_i),
    .wb_rst_ni     (wb_rst_ni),
    .cxrom_addr    (cxrom_addr),
    .cxrom_data_in (cxrom_data_in),
    .pc_load_i     (pc_load_i),
    .pc_i          (pc_i),
    .instr_ack_i   (instr_ack_i),
    .instr_len_i   (instr_len_i),
    .instr_valid_o (instr_valid_o),
    .instr_o       (instr_o),
    .instr_pc_o    (instr_pc_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  // ROM: byte at address a is a[7:0]
  assign cxrom_data_in = {8'(cxrom_addr + 16'd3), 8'(cxrom_addr + 16'd2),
                          8'(cxrom_addr + 16'd1), cxrom_addr[7:0]};

  typedef struct {
    bit          ld;
    logic [15:0] pc;
    bit          ack;
    logic [1:0]  len;
    bit          v;
    logic [15:0] epc;
    logic [31:0] einstr;
    logic [15:0] eaddr;
  } vec_t;

  vec_t tbl[$];

  // Reference model: queue of byte addresses buffered ahead of the core.
  logic [15:0] m_q[$];
  logic [15:0] m_pc, m_fa;
  bit          m_align;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add(input bit ld, input logic [15:0] p, input bit ack, input logic [1:0] len,
                     input bit v, input logic [15:0] epc, input logic [31:0] ei, input logic [15:0] ea);
    vec_t t;
    t.ld = ld; t.pc = p; t.ack = ack; t.len = len;
    t.v = v; t.epc = epc; t.einstr = ei; t.eaddr = ea;
    tbl.push_back(t);
  endtask

  task automatic drive(input bit ld, input logic [15:0] p, input bit ack, input logic [1:0] len);
    pc_load_i   = ld;
    pc_i        = p;
    instr_ack_i = ack;
    instr_len_i = len;
  endtask

  task automatic model_reset();
    m_q.delete();
    m_pc    = 16'h0000;
    m_fa    = 16'h0000;
    m_align = 1'b1;
  endtask

  function automatic logic [31:0] model_word();
    logic [31:0] w;
    w = '0;
    for (int k = 0; k < 4; k++) begin
      logic [15:0] a;
      a = m_q[k];
      w[8*k +: 8] = a[7:0];
    end
    return w;
  endfunction

  task automatic model_update(input bit ld, input logic [15:0] p, input bit ack, input logic [1:0] len);
    if (ld) begin
      m_q.delete();
      m_pc    = p;
      m_fa    = {p[15:2], 2'b00};
      m_align = 1'b1;
`ifdef OC8051_CXFETCH_BYPASS_EN
      for (int k = int'(p[1:0]); k < 4; k++) m_q.push_back(m_fa + 16'(k));
      m_fa    = m_fa + 16'd4;
      m_align = 1'b0;
`endif
    end else begin
      int  sz;
      int  skip;
      bit  fill;
      sz   = m_q.size();
      fill = (sz <= 4);
      skip = m_align ? int'(m_pc[1:0]) : 0;
      if (sz >= 4 && ack && len != 2'd0) begin
        for (int k = 0; k < int'(len); k++) void'(m_q.pop_front());
        m_pc = m_pc + {14'd0, len};
      end
      if (fill) begin
        for (int k = skip; k < 4; k++) m_q.push_back(m_fa + 16'(k));
        m_fa    = m_fa + 16'd4;
        m_align = 1'b0;
      end
    end
  endtask

  // One clock against the model; entered and left just after a falling edge.
  task automatic step(input bit ld, input logic [15:0] p, input bit ack, input logic [1:0] len);
    logic [15:0] exp_addr;
    bit          exp_v;
    drive(ld, p, ack, len);
    #1;
    exp_addr = m_fa;
`ifdef OC8051_CXFETCH_BYPASS_EN
    if (ld) exp_addr = {p[15:2], 2'b00};
`endif
    exp_v = (m_q.size() >= 4);
    check("valid", {31'd0, instr_valid_o}, {31'd0, exp_v});
    check("instr_pc", {16'd0, instr_pc_o}, {16'd0, m_pc});
    check("cxrom_addr", {16'd0, cxrom_addr}, {16'd0, exp_addr});
    if (exp_v) check("instr", instr_o, model_word());
    @(posedge wb_clk_i);
    model_update(ld, p, ack, len);
    @(negedge wb_clk_i);
  endtask

  initial begin
    int guard;

`ifdef OC8051_CXFETCH_BYPASS_EN
    add(0, 16'h0000, 0, 2'd0, 0, 16'h0000, 32'h0,        16'h0000);
    add(0, 16'h0000, 0, 2'd0, 1, 16'h0000, 32'h03020100, 16'h0004);
    add(1, 16'hFFFE, 1, 2'd3, 1, 16'h0000, 32'h03020100, 16'hFFFC);
    add(0, 16'h0000, 1, 2'd2, 0, 16'hFFFE, 32'h0,        16'h0000);
    add(0, 16'h0000, 1, 2'd2, 1, 16'hFFFE, 32'h0100FFFE, 16'h0004);
    add(0, 16'h0000, 0, 2'd0, 1, 16'h0000, 32'h03020100, 16'h0004);
    add(0, 16'h0000, 0, 2'd0, 1, 16'h0000, 32'h03020100, 16'h0008);
    add(1, 16'h1236, 0, 2'd0, 1, 16'h0000, 32'h03020100, 16'h1234);
    add(0, 16'h0000, 0, 2'd0, 0, 16'h1236, 32'h0,        16'h1238);
    add(0, 16'h0000, 0, 2'd0, 1, 16'h1236, 32'h39383736, 16'h123C);
`else
    add(0, 16'h0000, 0, 2'd0, 0, 16'h0000, 32'h0,        16'h0000);
    add(0, 16'h0000, 0, 2'd0, 1, 16'h0000, 32'h03020100, 16'h0004);
    add(1, 16'hFFFE, 1, 2'd3, 1, 16'h0000, 32'h03020100, 16'h0008);
    add(0, 16'h0000, 0, 2'd0, 0, 16'hFFFE, 32'h0,        16'hFFFC);
    add(0, 16'h0000, 1, 2'd2, 0, 16'hFFFE, 32'h0,        16'h0000);
    add(0, 16'h0000, 1, 2'd2, 1, 16'hFFFE, 32'h0100FFFE, 16'h0004);
    add(0, 16'h0000, 0, 2'd0, 1, 16'h0000, 32'h03020100, 16'h0004);
    add(0, 16'h0000, 0, 2'd0, 1, 16'h0000, 32'h03020100, 16'h0008);
    add(1, 16'h1236, 0, 2'd0, 1, 16'h0000, 32'h03020100, 16'h0008);
    add(0, 16'h0000, 0, 2'd0, 0, 16'h1236, 32'h0,        16'h1234);
    add(0, 16'h0000, 0, 2'd0, 0, 16'h1236, 32'h0,        16'h1238);
    add(0, 16'h0000, 0, 2'd0, 1, 16'h1236, 32'h39383736, 16'h123C);
`endif

    repeat (2) @(negedge wb_clk_i);
    check("rst_valid", {31'd0, instr_valid_o}, 32'd0);
    check("rst_pc", {16'd0, instr_pc_o}, 32'd0);
    check("rst_instr", instr_o, 32'd0);
    check("rst_addr", {16'd0, cxrom_addr}, 32'd0);
    wb_rst_ni = 1'b1;

    foreach (tbl[n]) begin
      drive(tbl[n].ld, tbl[n].pc, tbl[n].ack, tbl[n].len);
      #1;
      check($sformatf("tbl%0d_valid", n), {31'd0, instr_valid_o}, {31'd0, tbl[n].v});
      check($sformatf("tbl%0d_pc", n), {16'd0, instr_pc_o}, {16'd0, tbl[n].epc});
      check($sformatf("tbl%0d_addr", n), {16'd0, cxrom_addr}, {16'd0, tbl[n].eaddr});
      if (tbl[n].v) check($sformatf("tbl%0d_instr", n), instr_o, tbl[n].einstr);
      @(posedge wb_clk_i);
      @(negedge wb_clk_i);
    end

    drive(0, 16'h0000, 0, 2'd0);
    wb_rst_ni = 1'b0;
    @(negedge wb_clk_i);
    wb_rst_ni = 1'b1;
    model_reset();

    // Idle fill to a full queue, then continuous three-byte consumption.
    repeat (3) step(0, 16'h0000, 0, 2'd0);
    repeat (30) step(0, 16'h0000, 1, 2'd3);

    // Walk to 0x0040 and reset asynchronously mid-stream.
    model_reset();
    wb_rst_ni = 1'b0;
    @(negedge wb_clk_i);
    wb_rst_ni = 1'b1;
    guard = 0;
    while (m_pc != 16'h0040 && guard < 400) begin
      step(0, 16'h0000, 1, 2'd1);
      guard++;
    end
    check("reach_0040", {16'd0, instr_pc_o}, 32'h0040);
    #2 wb_rst_ni = 1'b0;
    #1;
    check("async_valid", {31'd0, instr_valid_o}, 32'd0);
    check("async_pc", {16'd0, instr_pc_o}, 32'd0);
    check("async_instr", instr_o, 32'd0);
    @(negedge wb_clk_i);
    wb_rst_ni = 1'b1;
    model_reset();
    repeat (4) step(0, 16'h0000, 1, 2'd2);

    for (int n = 0; n < 3000; n++) begin
      bit          ld;
      logic [15:0] p;
      ld = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 1) == 0) p = 16'($urandom_range(16'hFFF0, 16'hFFFF));
      else                           p = 16'($urandom);
      step(ld, p, ($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
